// File: rtl/if_id_reg_pkg.sv
// Shared CPU definitions: reset/handler vectors, exception codes and the NOP
// encoding used by the fetch, decode and CP0 stages.
package if_id_reg_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Register bundle carried between fetch and decode; id_ex_reg reuses the
  // same reset > flush > stall > load priority over its own bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } if_id_bundle_t;

  localparam if_id_bundle_t RESET_BUNDLE =
    '{pc: RESET_PC, instr: NOP_INSTR, exc: 5'd0, bd: 1'b0, valid: 1'b0};
  localparam if_id_bundle_t FLUSH_BUNDLE =
    '{pc: HANDLER_PC, instr: NOP_INSTR, exc: 5'd0, bd: 1'b0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register: holds PC, instruction, fetch exception and
// delay-slot flag for decode, with stall, flush and fetch-fault sanitising.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_F,
  input  logic [31:0] instr_F,
  input  logic [4:0]  exc_F,
  input  logic        branch_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic [31:0] instr_D,
  output logic [4:0]  exc_D,
  output logic        bd_D,
  output logic        valid_D
);

  if_id_bundle_t state_p1;
  if_id_bundle_t load_p0;

  // A faulting fetch must never reach decode as a real opcode; the exception
  // code alone travels on to the commit point.
  function automatic logic [31:0] sanitise_instr(input logic [31:0] instr,
                                                 input logic [4:0]  exc);
    return (exc == 5'd0) ? instr : NOP_INSTR;
  endfunction

  always_comb begin
    load_p0       = '0;
    load_p0.pc    = pc_F;
    load_p0.instr = sanitise_instr(instr_F, exc_F);
    load_p0.exc   = exc_F;
    load_p0.bd    = branch_D;
    load_p0.valid = 1'b1;
  end

  // F -> D stage boundary
  always_ff @(posedge clk) begin
    if (reset)       state_p1 <= RESET_BUNDLE;
    else if (flush)  state_p1 <= FLUSH_BUNDLE;
    else if (!stall) state_p1 <= load_p0;
  end

  assign pc_D    = state_p1.pc;
  assign pc8_D   = state_p1.pc + 32'd8;
  assign instr_D = state_p1.instr;
  assign exc_D   = state_p1.exc;
  assign bd_D    = state_p1.bd;
  assign valid_D = state_p1.valid;

endmodule

// File: doc/if_id_reg.md
# if_id_reg

Fetch/decode pipeline register of the five-stage MIPS core. It sits directly downstream of the program-counter register and instruction memory, and captures PC, instruction word, fetch exception code and branch-delay-slot flag for the decode stage. It implements stall (hold), flush (bubble insertion on exception/ERET redirect) and fetch-fault sanitising, so that decode never acts on a faulting fetch.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value presented in decode after reset.
- `HANDLER_PC`, 32'h0000_4180, PC value tagged on a flush bubble.
- `EXC_ADEL`, 5'd4, fetch exception code for address error on fetch.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold; the register keeps its contents.
- `flush`  in  1  exception/interrupt/ERET taken this cycle; load a bubble.
- `pc_F`  in  32  PC of the instruction being fetched.
- `instr_F`  in  32  instruction-memory read data at `pc_F`.
- `exc_F`  in  5  fetch exception code; 0 = none, `EXC_ADEL` = misaligned or out-of-range PC.
- `branch_D`  in  1  the instruction now in decode is a branch or jump, so the fetched one is its delay slot.
- `pc_D`  out  32  PC of the decode-stage instruction.
- `pc8_D`  out  32  `pc_D + 8`, the link address.
- `instr_D`  out  32  decode-stage instruction word.
- `exc_D`  out  5  fetch exception carried into decode.
- `bd_D`  out  1  the decode instruction is in a branch delay slot.
- `valid_D`  out  1  1 = real instruction, 0 = bubble.

## Operation
- Priority at each edge: reset > flush > stall > load.
- Reset: `pc_D`=`RESET_PC`, `instr_D`=0, `exc_D`=0, `bd_D`=0, `valid_D`=0. `pc8_D` follows `pc_D` (32'h0000_3008).
- Flush: `pc_D`=`HANDLER_PC`, `instr_D`=0, `exc_D`=0, `bd_D`=0, `valid_D`=0.
  - Flush overrides a simultaneous stall.
  - A fetch fault present in the same cycle is discarded.
- Stall without flush: every register holds. `branch_D` is ignored, because the decode instruction is unchanged.
- Load: `pc_D`=`pc_F`, `exc_D`=`exc_F`, `bd_D`=`branch_D`, `valid_D`=1.
  - `instr_D`=`instr_F` when `exc_F`==0; otherwise `instr_D`=32'h0 (nop). The exception code still travels to the commit point.
- `bd_D` is captured from `branch_D` sampled in the loading cycle only. Consecutive branch/jump pairs are each tagged independently.
- `pc8_D` is combinational from the registered `pc_D`, using a 32-bit wrapping add (32'hFFFF_FFFC → 32'h0000_0004). It adds no register stage.
- No internal check of `pc_F`: the fault decision belongs to the PC stage and arrives via `exc_F`.

## Timing
- Latency: one cycle, F→D. Inputs sampled at edge N appear on outputs after edge N.
- `stall` held for K cycles freezes the outputs for exactly K edges. The load resumes on the first edge with `stall`=0.
- Flush produces a bubble visible for one cycle. The next edge loads normally, unless stalled or flushed again.
- Reset asserted mid-stall or mid-flush takes effect on the next edge regardless of other inputs.
- No combinational path from any input to any output. All outputs are registered, except `pc8_D`, which derives from a register only.

## Structure
- Shared CPU package or header holds: `RESET_PC`, `HANDLER_PC`, `EXC_ADEL` and the full exception-code enumeration (shared with the PC stage, decode and CP0), plus the NOP encoding 32'h0.
- Single flat module; no sub-module. The pipeline-register bundle is generic enough that the later `id_ex_reg` reuses the same priority scheme.

## Test plan
- Reset then load: assert reset 1 cycle → outputs `pc_D`=32'h3000, `pc8_D`=32'h3008, `valid_D`=0. Then `pc_F`=32'h3000, `instr_F`=32'h3C01_1234 → after next edge `pc_D`=32'h3000, `instr_D`=32'h3C01_1234, `valid_D`=1, `exc_D`=0.
- Stall hold: load 32'h3004/32'h0000_0000, then `stall`=1 for 3 edges while `pc_F` changes to 32'h3008 → `pc_D` stays 32'h3004 for 3 cycles, then becomes 32'h3008 one edge after release.
- Delay slot: `branch_D`=1 while `pc_F`=32'h3010 → `bd_D`=1, `pc_D`=32'h3010. The next load with `branch_D`=0 → `bd_D`=0.
- Fetch fault: `pc_F`=32'h3002, `exc_F`=4, `instr_F`=32'hDEAD_BEEF → `instr_D`=0, `exc_D`=4, `valid_D`=1.
- Flush beats stall: `stall`=1 and `flush`=1 together → `pc_D`=32'h4180, `instr_D`=0, `valid_D`=0, `bd_D`=0. The next edge, with no stall, loads `pc_F`=32'h4180 normally.
- Reset mid-stall: `stall`=1 with `reset`=1 for one edge → all outputs at reset values.
